// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for the sequential signed divider.
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;

  modport master (
    output ctrl_DIV, data_operandA, data_operandB,
    input  data_result, data_exception, data_resultRDY
  );

  modport slave (
    input  ctrl_DIV, data_operandA, data_operandB,
    output data_result, data_exception, data_resultRDY
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: restoring shift-subtract on magnitudes, one
// quotient bit per clock, quotient truncated toward zero. A start pulse
// launches an op (restarting any op in flight); a one-cycle ready pulse
// reports completion, with a divide-by-zero flag valid alongside it.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset,
  seq_divider_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic             r_neg;
  logic             r_div0;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;
  logic             r_rdy;

  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_trial;

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  // The shifted partial remainder fits in WIDTH bits because rem < |B|, so the
  // extra top bit only serves as the borrow of the trial subtraction.
  always_comb begin
    w_absA  = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
    w_absB  = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_trial = w_shift - {1'b0, r_div};
  end

  // Control FSM and datapath; a start pulse takes priority in every state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg    <= 1'b0;
      r_div0   <= 1'b0;
      r_result <= '0;
      r_exc    <= 1'b0;
      r_rdy    <= 1'b0;
    end else begin
      r_rdy <= 1'b0;
      r_exc <= 1'b0;
      if (bus.ctrl_DIV) begin
        r_quo   <= w_absA;
        r_div   <= w_absB;
        r_neg   <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        r_rem   <= '0;
        r_cnt   <= '0;
        r_div0  <= (bus.data_operandB == '0);
        r_state <= (bus.data_operandB == '0) ? S_DONE : S_RUN;
      end else begin
        case (r_state)
          S_RUN: begin
            if (!w_trial[WIDTH]) begin
              r_rem <= w_trial[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
              r_rem <= w_shift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(WIDTH - 1)) begin
              r_state <= S_DONE;
            end
          end
          S_DONE: begin
            if (r_div0) begin
              r_result <= '0;
              r_exc    <= 1'b1;
            end else begin
              r_result <= r_neg ? -r_quo : r_quo;
            end
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exc;
  assign bus.data_resultRDY = r_rdy;
endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider with hand-computed expectations.
module tb_seq_divider;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rdy_pulses = 0;
  int   base;
  int   lat;

  seq_divider_if #(.WIDTH(32)) bus ();

  seq_divider #(.WIDTH(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Count every high cycle of the ready pulse, sampled mid-cycle.
  always @(negedge clock) begin
    if (bus.data_resultRDY === 1'b1) rdy_pulses++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse ctrl_DIV for exactly one rising edge; returns 1 time unit after it.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_DIV      = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_DIV = 1'b0;
  endtask

  // Edges after the start edge until RDY is seen high; 0 if the bound expires.
  task automatic wait_rdy(output int cycles);
    cycles = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (bus.data_resultRDY === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc, input int exp_lat);
    int l;
    start(a, b);
    wait_rdy(l);
    chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
    chk({tag, "_res"}, 64'(bus.data_result), 64'(exp_res));
    chk({tag, "_exc"}, 64'(bus.data_exception), 64'(exp_exc));
    @(posedge clock);
    #1;
    chk({tag, "_rdy_drop"}, 64'(bus.data_resultRDY), 64'(1'b0));
    chk({tag, "_exc_drop"}, 64'(bus.data_exception), 64'(1'b0));
    chk({tag, "_hold"}, 64'(bus.data_result), 64'(exp_res));
  endtask

  initial begin
    bus.ctrl_DIV      = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_res", 64'(bus.data_result), 64'h0);
    chk("rst_exc", 64'(bus.data_exception), 64'h0);
    chk("rst_rdy", 64'(bus.data_resultRDY), 64'h0);
    @(negedge clock);
    reset = 1'b0;

    // Basic and signed quotients
    run_op("p7_2",   32'd7,          32'd2,          32'd3,          1'b0, 33);
    run_op("n7_2",   32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  1'b0, 33);
    run_op("p7_n2",  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  1'b0, 33);
    run_op("n7_n2",  32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          1'b0, 33);

    // Divide by zero
    run_op("div0",   32'd100,        32'd0,          32'd0,          1'b1, 1);

    // Boundaries
    run_op("min_1",  32'h8000_0000,  32'd1,          32'h8000_0000,  1'b0, 33);
    run_op("min_m1", 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1'b0, 33);
    run_op("max_max",32'h7FFF_FFFF,  32'h7FFF_FFFF,  32'd1,          1'b0, 33);
    run_op("p3_5",   32'd3,          32'd5,          32'd0,          1'b0, 33);
    run_op("n3_5",   32'hFFFF_FFFD,  32'd5,          32'd0,          1'b0, 33);

    // Restart mid-run: first op discarded, single RDY for the second
    base = rdy_pulses;
    start(32'd50, 32'd5);
    repeat (9) begin
      @(posedge clock);
      #1;
    end
    start(32'd9, 32'd3);
    wait_rdy(lat);
    chk("rs_lat", 64'(lat), 64'd33);
    chk("rs_res", 64'(bus.data_result), 64'd3);
    repeat (3) @(posedge clock);
    #1;
    chk("rs_pulses", 64'(rdy_pulses - base), 64'd1);

    // Restart on the edge that would assert RDY: restart wins
    base = rdy_pulses;
    start(32'd7, 32'd2);
    repeat (32) begin
      @(posedge clock);
      #1;
    end
    start(32'd40, 32'hFFFF_FFF8);
    chk("rsd_no_rdy", 64'(bus.data_resultRDY), 64'h0);
    wait_rdy(lat);
    chk("rsd_lat", 64'(lat), 64'd33);
    chk("rsd_res", 64'(bus.data_result), 64'hFFFF_FFFB);
    repeat (3) @(posedge clock);
    #1;
    chk("rsd_pulses", 64'(rdy_pulses - base), 64'd1);

    // Reset mid-operation aborts at once, no RDY afterwards
    base = rdy_pulses;
    start(32'd50, 32'd5);
    repeat (14) begin
      @(posedge clock);
      #1;
    end
    reset = 1'b1;
    #1;
    chk("ar_res", 64'(bus.data_result), 64'h0);
    chk("ar_exc", 64'(bus.data_exception), 64'h0);
    chk("ar_rdy", 64'(bus.data_resultRDY), 64'h0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(posedge clock);
    #1;
    chk("ar_pulses", 64'(rdy_pulses - base), 64'd0);
    chk("ar_res_idle", 64'(bus.data_result), 64'h0);
    run_op("post_rst", 32'hFFFF_FFEC, 32'd4, 32'hFFFF_FFFB, 1'b0, 33);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
